ex_operand_stage: RTL and testbench

ID/EX pipeline register plus operand-forwarding network that drives the ALU's `SrcA`, `SrcB` and `Operation` inputs. It captures decoded operands and control from the decode stage, holds them across stalls, and kills them on flush. It also substitutes in-flight results from the EX/MEM and MEM/WB stages, so the ALU always sees architecturally current register values. It sits between decode and the ALU.

---
 rtl/ex_pkg.sv | 17 +
 rtl/forward_unit.sv | 29 ++
 rtl/ex_operand_stage.sv | 134 +++++++++++++
 tb/tb_ex_operand_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the EX operand stage: forwarding selects and ALU opcodes.
package ex_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_NE  = 4'b1001;

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding select for one source operand.
// EX/MEM wins over MEM/WB, and x0 is never forwarded.
module forward_unit
    import ex_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    output fwd_sel_e                  fwd
);

    logic rs_nonzero;

    assign rs_nonzero = (rs != '0);

    always_comb begin
        fwd = FWD_NONE;
        if (exmem_reg_write && (exmem_rd == rs) && rs_nonzero) begin
            fwd = FWD_MEM;
        end else if (memwb_reg_write && (memwb_rd == rs) && rs_nonzero) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding feeding the ALU.
// Outputs to the ALU are forced to zero while the stage holds no live instruction.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_reg_write,
    input  logic                      exmem_reg_write,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      ex_valid,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_reg_write,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [1:0]                fwd_a,
    output logic [1:0]                fwd_b
);

    logic                      valid_q;
    logic                      reg_write_q;
    logic                      alu_src_q;
    logic [DATA_WIDTH-1:0]     rs1_data_q;
    logic [DATA_WIDTH-1:0]     rs2_data_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [OPCODE_LENGTH-1:0]  alu_op_q;

    // Flush only kills the valid/write bits; datapath registers may keep stale values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= id_valid;
            reg_write_q <= id_reg_write;
            alu_src_q   <= id_alu_src;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            alu_op_q    <= id_alu_op;
        end
    end

    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs              (rs1_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd             (sel_a)
    );

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs              (rs2_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd             (sel_b)
    );

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    always_comb begin
        op_a = rs1_data_q;
        case (sel_a)
            FWD_MEM: op_a = exmem_result;
            FWD_WB:  op_a = memwb_result;
            default: op_a = rs1_data_q;
        endcase
    end

    always_comb begin
        op_b = rs2_data_q;
        case (sel_b)
            FWD_MEM: op_b = exmem_result;
            FWD_WB:  op_b = memwb_result;
            default: op_b = rs2_data_q;
        endcase
    end

    assign SrcA          = valid_q ? op_a : '0;
    assign SrcB          = valid_q ? (alu_src_q ? imm_q : op_b) : '0;
    assign Operation     = valid_q ? alu_op_q : '0;
    assign fwd_a         = valid_q ? sel_a : FWD_NONE;
    assign fwd_b         = valid_q ? sel_b : FWD_NONE;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_store_data = op_b;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, capture, forwarding priority, x0 guard,
// immediate vs store data, stall hold and flush.
module tb_ex_operand_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, stall, flush;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write;
    logic [4:0]  ex_rd;
    logic [1:0]  fwd_a, fwd_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .stall           (stall),
        .flush           (flush),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_alu_src      (id_alu_src),
        .id_alu_op       (id_alu_op),
        .id_reg_write    (id_reg_write),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_rd        (memwb_rd),
        .exmem_result    (exmem_result),
        .memwb_result    (memwb_result),
        .SrcA            (SrcA),
        .SrcB            (SrcB),
        .Operation       (Operation),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_store_data   (ex_store_data),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_downstream();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src,
                          input logic [3:0] op, input logic [4:0] rd, input logic we);
        id_valid = 1'b1;
        id_rs1 = rs1; id_rs1_data = d1;
        id_rs2 = rs2; id_rs2_data = d2;
        id_imm = imm; id_alu_src = src; id_alu_op = op;
        id_rd = rd; id_reg_write = we;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ex_valid"},     {31'd0, ex_valid},     32'd0);
        chk({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, 32'd0);
        chk({tag, ".SrcA"},         SrcA,                  32'd0);
        chk({tag, ".SrcB"},         SrcB,                  32'd0);
        chk({tag, ".Operation"},    {28'd0, Operation},    32'd0);
        chk({tag, ".fwd_a"},        {30'd0, fwd_a},        32'd0);
        chk({tag, ".fwd_b"},        {30'd0, fwd_b},        32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        clear_downstream();
        // Reset must win even though decode presents a valid instruction.
        set_id(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, ALU_ADD, 5'd9, 1'b1);
        step();
        step();
        chk_idle("rst");
        chk("rst.ex_rd",         {27'd0, ex_rd}, 32'd0);
        chk("rst.ex_store_data", ex_store_data,  32'd0);

        reset = 1'b0;
        step();
        chk("cap.SrcA",         SrcA,                  32'd5);
        chk("cap.SrcB",         SrcB,                  32'd7);
        chk("cap.Operation",    {28'd0, Operation},    32'h2);
        chk("cap.ex_valid",     {31'd0, ex_valid},     32'd1);
        chk("cap.ex_rd",        {27'd0, ex_rd},        32'd9);
        chk("cap.ex_reg_write", {31'd0, ex_reg_write}, 32'd1);

        // Forwarding priority on rs1 = x3
        set_id(5'd3, 32'h11, 5'd6, 32'h22, 32'd0, 1'b0, ALU_SUB, 5'd8, 1'b1);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
        #1;
        chk("fp.mem.SrcA",  SrcA,           32'hAA);
        chk("fp.mem.fwd_a", {30'd0, fwd_a}, 32'h2);
        chk("fp.mem.SrcB",  SrcB,           32'h22);
        chk("fp.mem.fwd_b", {30'd0, fwd_b}, 32'h0);
        exmem_reg_write = 1'b0;
        #1;
        chk("fp.wb.SrcA",  SrcA,           32'hBB);
        chk("fp.wb.fwd_a", {30'd0, fwd_a}, 32'h1);
        exmem_reg_write = 1'b1; exmem_rd = 5'd4; memwb_reg_write = 1'b0;
        #1;
        chk("fp.miss.SrcA",  SrcA,           32'h11);
        chk("fp.miss.fwd_a", {30'd0, fwd_a}, 32'h0);
        clear_downstream();

        // x0 never forwarded
        set_id(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, ALU_AND, 5'd0, 1'b0);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h55;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h66;
        #1;
        chk("x0.SrcB",  SrcB,           32'd0);
        chk("x0.fwd_b", {30'd0, fwd_b}, 32'd0);
        chk("x0.SrcA",  SrcA,           32'd0);
        clear_downstream();

        // Immediate on SrcB while store data still forwards rs2
        set_id(5'd1, 32'h3, 5'd4, 32'h9, 32'hFFFF_FFFC, 1'b1, ALU_ADD, 5'd5, 1'b1);
        step();
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h1234;
        #1;
        chk("imm.SrcB",       SrcB,           32'hFFFF_FFFC);
        chk("imm.store_data", ex_store_data,  32'h1234);
        chk("imm.fwd_b",      {30'd0, fwd_b}, 32'h1);
        chk("imm.SrcA",       SrcA,           32'h3);
        clear_downstream();

        // Stall holds instruction A while decode changes underneath
        set_id(5'd1, 32'h100, 5'd2, 32'h200, 32'h0, 1'b0, ALU_OR, 5'd7, 1'b1);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(5'd10 + 5'(i), 32'hDEAD_0000 + 32'(i), 5'd11, 32'hBEEF, 32'h1,
                   1'b1, ALU_NE, 5'd12, 1'b0);
            step();
            chk("stall.SrcA",      SrcA,               32'h100);
            chk("stall.SrcB",      SrcB,               32'h200);
            chk("stall.Operation", {28'd0, Operation}, 32'h1);
            chk("stall.ex_rd",     {27'd0, ex_rd},     32'd7);
        end
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'hCAFE;
        #1;
        chk("stall.live_fwd", SrcA, 32'hCAFE);

        // Flush together with stall still kills the stage
        flush = 1'b1;
        step();
        chk_idle("flush");
        flush = 1'b0; stall = 1'b0;
        clear_downstream();

        // Capture with reg_write=0, then reset mid-instruction
        set_id(5'd2, 32'h44, 5'd3, 32'h55, 32'h0, 1'b0, ALU_EQ, 5'd6, 1'b0);
        step();
        chk("nowr.Operation",    {28'd0, Operation},    32'h8);
        chk("nowr.ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        set_id(5'd2, 32'h44, 5'd3, 32'h55, 32'h0, 1'b0, ALU_ADD, 5'd6, 1'b1);
        reset = 1'b1;
        step();
        chk_idle("midrst");
        reset = 1'b0;
        id_valid = 1'b0;
        step();
        chk("inval.ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("inval.SrcA",     SrcA,              32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
